// File: rtl/mat_dump_if.sv
// Memory request port and output element stream between mat_dump and its neighbours.
// master = mat_dump side, slave = memory model / stream consumer side.
interface mat_dump_if #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32
);
  logic              mem_req;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_rdata_vld;
  logic [MEM_DW-1:0] mem_rdata;
  logic              s_valid;
  logic              s_ready;
  logic [MEM_DW-1:0] s_data;
  logic              s_eol;
  logic              s_last;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata_vld, mem_rdata,
    output s_valid, s_data, s_eol, s_last,
    input  s_ready
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata_vld, mem_rdata,
    input  s_valid, s_data, s_eol, s_last,
    output s_ready
  );
endinterface

// File: rtl/mat_dump.sv
// Reads a ROWS x COLS matrix row-major from word memory (one read in flight)
// and streams each element out with end-of-row and end-of-matrix markers.
module mat_dump #(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int DIM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  output logic                ret,
  input  logic [MEM_AW-1:0]   BASE,
  input  logic [DIM_BITS-1:0] STRIDE,
  input  logic [DIM_BITS-1:0] ROWS,
  input  logic [DIM_BITS-1:0] COLS,
  mat_dump_if.master          bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [DIM_BITS-1:0] ONE_D  = {{(DIM_BITS-1){1'b0}}, 1'b1};
  localparam logic [DIM_BITS-1:0] ZERO_D = {DIM_BITS{1'b0}};

  // Zero-extend or truncate a dimension-width value onto the address width.
  function automatic logic [MEM_AW-1:0] to_aw(input logic [DIM_BITS-1:0] v);
    logic [MEM_AW+DIM_BITS-1:0] t;
    t = {{MEM_AW{1'b0}}, v};
    return t[MEM_AW-1:0];
  endfunction

  state_t              r_state;
  logic [MEM_AW-1:0]   r_row_addr;
  logic [MEM_AW-1:0]   r_stride;
  logic [DIM_BITS-1:0] r_rows;
  logic [DIM_BITS-1:0] r_cols;
  logic [DIM_BITS-1:0] r_r;
  logic [DIM_BITS-1:0] r_c;
  logic                r_ret;
  logic                r_mem_req;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic                r_s_valid;
  logic [MEM_DW-1:0]   r_s_data;
  logic                r_s_eol;
  logic                r_s_last;

  logic                w_last_col;
  logic                w_last_row;
  logic                w_hs;
  logic [DIM_BITS-1:0] w_next_c;
  logic [MEM_AW-1:0]   w_next_row_addr;
  logic [MEM_AW-1:0]   w_next_col_addr;

  assign w_last_col      = (r_c == (r_cols - ONE_D));
  assign w_last_row      = (r_r == (r_rows - ONE_D));
  assign w_hs            = r_s_valid & bus.s_ready;
  assign w_next_c        = r_c + ONE_D;
  assign w_next_row_addr = r_row_addr + r_stride;
  assign w_next_col_addr = r_row_addr + to_aw(w_next_c);

  // Control FSM: every output is set on the transition into the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_row_addr <= {MEM_AW{1'b0}};
      r_stride   <= {MEM_AW{1'b0}};
      r_rows     <= ZERO_D;
      r_cols     <= ZERO_D;
      r_r        <= ZERO_D;
      r_c        <= ZERO_D;
      r_ret      <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= {MEM_AW{1'b0}};
      r_s_valid  <= 1'b0;
      r_s_data   <= {MEM_DW{1'b0}};
      r_s_eol    <= 1'b0;
      r_s_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ret <= 1'b0;
          if (go) begin
            r_stride   <= to_aw(STRIDE);
            r_rows     <= ROWS;
            r_cols     <= COLS;
            r_r        <= ZERO_D;
            r_c        <= ZERO_D;
            r_row_addr <= BASE;
            if ((ROWS == ZERO_D) || (COLS == ZERO_D)) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= BASE;
            end
          end
        end
        S_REQ: begin
          r_mem_req <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_rdata_vld) begin
            r_s_data  <= bus.mem_rdata;
            r_s_eol   <= w_last_col;
            r_s_last  <= w_last_col & w_last_row;
            r_s_valid <= 1'b1;
            r_state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (w_hs) begin
            r_s_valid <= 1'b0;
            if (r_s_last) begin
              r_ret   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_last_col) begin
              r_c        <= ZERO_D;
              r_r        <= r_r + ONE_D;
              r_row_addr <= w_next_row_addr;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_next_row_addr;
              r_state    <= S_REQ;
            end else begin
              r_c        <= w_next_c;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_next_col_addr;
              r_state    <= S_REQ;
            end
          end
        end
        S_DONE: begin
          // After a dump ret is already high here and drops; an empty run has
          // not pulsed yet, so it pulses on the way back to IDLE instead.
          r_ret   <= ~r_ret;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ret           = r_ret;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_write = 1'b0;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = {MEM_DW{1'b0}};
  assign bus.s_valid   = r_s_valid;
  assign bus.s_data    = r_s_data;
  assign bus.s_eol     = r_s_eol;
  assign bus.s_last    = r_s_last;

endmodule
